// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence player: FSM encoding, bus width defaults, LED-off value.
package seq_pkg;

  localparam int unsigned P_ADDR_DEF = 4;
  localparam int unsigned P_LED_DEF  = 4;
  localparam int unsigned P_TMR      = 8;

  localparam logic [P_LED_DEF-1:0] LED_OFF = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHOW  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/hold_timer.sv
// Loadable tick down-counter; expire pulses when a tick takes the count from 1 to 0.
module hold_timer
  import seq_pkg::*;
#(
  parameter int unsigned P_W = P_TMR
) (
  input  logic           clk,
  input  logic           R,
  input  logic           load,
  input  logic [P_W-1:0] load_val,
  input  logic           tick,
  output logic           expire
);

  logic [P_W-1:0] cnt_q, cnt_d;

  // Load wins over a tick; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - P_W'(1);
    end
  end

  assign expire = tick && (cnt_q == P_W'(1));

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sequence_player.sv
// Plays ROM patterns 0..round on the LEDs with tick-timed show/gap holds.
// Optional SEQ_PLAYER_SPEEDUP_EN shortens the show hold on later rounds.
module sequence_player
  import seq_pkg::*;
#(
  parameter int unsigned P_ADDR     = P_ADDR_DEF,
  parameter int unsigned P_LED      = P_LED_DEF,
  parameter int unsigned SHOW_TICKS = 2,
  parameter int unsigned GAP_TICKS  = 1
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic              abort,
  input  logic [P_ADDR-1:0] round,
  input  logic              tick,
  input  logic [P_LED-1:0]  rom_data,
  output logic [P_ADDR-1:0] rom_addr,
  output logic [P_LED-1:0]  leds,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [P_ADDR-1:0] rom_addr_q, rom_addr_d;
  logic [P_ADDR-1:0] limit_q, limit_d;
  logic [P_LED-1:0]  leds_q, leds_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tmr_load;
  logic [P_TMR-1:0]  tmr_val;
  logic              tmr_tick;
  logic              tmr_expire;
  logic [P_TMR-1:0]  show_val;

`ifdef SEQ_PLAYER_SPEEDUP_EN
  logic [P_TMR-1:0] show_full;
  logic [P_TMR-1:0] show_shr;
  assign show_full = P_TMR'(SHOW_TICKS);
  assign show_shr  = show_full >> limit_q[3:2];
  assign show_val  = (show_shr == '0) ? P_TMR'(1) : show_shr;
`else
  assign show_val = P_TMR'(SHOW_TICKS);
`endif

  // Ticks only count while a hold is running; anywhere else they are dropped.
  assign tmr_tick = tick && !abort && ((state_q == SHOW) || (state_q == GAP));

  hold_timer #(.P_W(P_TMR)) u_hold_timer (
    .clk      (clk),
    .R        (R),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tmr_tick),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    limit_d    = limit_q;
    leds_d     = leds_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    if (abort) begin
      state_d  = IDLE;
      leds_d   = P_LED'(LED_OFF);
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            limit_d    = round;
            rom_addr_d = '0;
            state_d    = FETCH;
          end
        end
        FETCH: begin
          leds_d   = rom_data;
          tmr_load = 1'b1;
          tmr_val  = show_val;
          state_d  = SHOW;
        end
        SHOW: begin
          if (tmr_expire) begin
            leds_d   = P_LED'(LED_OFF);
            tmr_load = 1'b1;
            tmr_val  = P_TMR'(GAP_TICKS);
            state_d  = GAP;
          end
        end
        GAP: begin
          if (tmr_expire) begin
            if (rom_addr_q == limit_q) begin
              state_d = DONE;
            end else begin
              rom_addr_d = rom_addr_q + P_ADDR'(1);
              state_d    = FETCH;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      limit_q    <= '0;
      leds_q     <= P_LED'(LED_OFF);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      limit_q    <= limit_d;
      leds_q     <= leds_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign leds     = leds_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Randomized bench for sequence_player: playback is cut into lit runs and dark gaps and compared with the expected step list.
module tb_sequence_player;

  localparam int unsigned AW   = 4;
  localparam int unsigned LW   = 4;
  localparam int unsigned SHOW = 2;
  localparam int unsigned GAP  = 1;
  localparam int          BUDGET = 2000;

  logic          clk = 1'b0;
  logic          R;
  logic          start;
  logic          abort;
  logic          tick;
  logic [AW-1:0] round;
  logic [LW-1:0] rom_data;
  logic [AW-1:0] rom_addr;
  logic [LW-1:0] leds;
  logic          busy;
  logic          done;

  logic [LW-1:0] rom [16];
  int            checks = 0;
  int            errors = 0;
  int            tick_cd = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  sequence_player #(
    .P_ADDR     (AW),
    .P_LED      (LW),
    .SHOW_TICKS (SHOW),
    .GAP_TICKS  (GAP)
  ) dut (
    .clk      (clk),
    .R        (R),
    .start    (start),
    .abort    (abort),
    .round    (round),
    .tick     (tick),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .leds     (leds),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected number of ticks each pattern stays lit for a given round.
  function automatic int exp_hold(input int rnd);
`ifdef SEQ_PLAYER_SPEEDUP_EN
    int h;
    h = int'(SHOW) >> ((rnd >> 2) & 3);
    return (h < 1) ? 1 : h;
`else
    return int'(SHOW);
`endif
  endfunction

  // Ticks are always at least two cycles apart.
  task automatic drive_tick();
    if (tick_cd == 0) begin
      tick    = 1'b1;
      tick_cd = $urandom_range(1, 4);
    end else begin
      tick    = 1'b0;
      tick_cd = tick_cd - 1;
    end
  endtask

  task automatic run_play(input int rnd, input bit disturb, input bit rand_rom);
    int  first_k, done_k, exit_k, done_cnt, done_addr, run_ticks, gap_ticks;
    bit  in_lit, in_gap;
    int  pats[$];
    int  addrs[$];
    int  runs[$];
    int  gaps[$];
    if (rand_rom) begin
      for (int i = 0; i < 16; i++) rom[i] = LW'($urandom_range(1, 15));
    end
    @(negedge clk);
    round = AW'(rnd);
    start = 1'b1;
    tick  = 1'b0;
    tick_cd = $urandom_range(0, 3);
    first_k = -1; done_k = -1; exit_k = -1; done_cnt = 0; done_addr = -1;
    run_ticks = 0; gap_ticks = 0; in_lit = 1'b0; in_gap = 1'b0;
    for (int k = 1; k <= BUDGET && exit_k < 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (disturb && k == 5) begin
        start = 1'b1;
        round = AW'($urandom);
      end
      if (disturb && k == 9) round = AW'($urandom);
      drive_tick();
      if (leds != '0) begin
        if (!in_lit) begin
          if (in_gap) gaps.push_back(gap_ticks);
          in_gap = 1'b0;
          in_lit = 1'b1;
          run_ticks = 0;
          pats.push_back(int'(leds));
          addrs.push_back(int'(rom_addr));
          if (first_k < 0) first_k = k;
        end
        if (tick) run_ticks++;
      end else begin
        if (in_lit) begin
          runs.push_back(run_ticks);
          in_lit = 1'b0;
          in_gap = 1'b1;
          gap_ticks = 0;
        end
        if (done) begin
          if (in_gap) gaps.push_back(gap_ticks);
          in_gap = 1'b0;
          done_cnt++;
          done_k = k;
          done_addr = int'(rom_addr);
        end else if (in_gap && tick) begin
          gap_ticks++;
        end
      end
      if (!busy) exit_k = k;
    end
    tick = 1'b0;
    check("play_terminates", 32'(exit_k > 0), 32'd1);
    check("first_lit_latency", 32'(first_k), 32'd2);
    check("step_count", 32'(pats.size()), 32'(rnd + 1));
    for (int i = 0; i <= rnd; i++) begin
      if (i < pats.size()) begin
        check("step_pattern", 32'(pats[i]), 32'(rom[i]));
        check("step_addr", 32'(addrs[i]), 32'(i));
      end
      if (i < runs.size()) check("show_ticks", 32'(runs[i]), 32'(exp_hold(rnd)));
      if (i < gaps.size()) check("gap_ticks", 32'(gaps[i]), 32'(GAP));
    end
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_addr", 32'(done_addr), 32'(rnd));
    check("busy_falls_after_done", 32'(exit_k), 32'(done_k + 1));
  endtask

  task automatic run_abort();
    bit hit;
    int bad;
    for (int i = 0; i < 16; i++) rom[i] = LW'($urandom_range(1, 15));
    @(negedge clk);
    round = AW'(5);
    start = 1'b1;
    tick  = 1'b0;
    tick_cd = 1;
    hit = 1'b0;
    for (int k = 1; k <= BUDGET && !hit; k++) begin
      @(negedge clk);
      start = 1'b0;
      round = AW'($urandom);
      drive_tick();
      if (leds != '0 && rom_addr == AW'(2)) begin
        hit   = 1'b1;
        abort = 1'b1;
        start = 1'b1;
      end
    end
    check("abort_reached_step2", 32'(hit), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    tick  = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_leds", 32'(leds), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      tick = 1'($urandom_range(0, 1));
      if (done || busy) bad++;
    end
    tick = 1'b0;
    check("abort_stays_idle", 32'(bad), 32'd0);
  endtask

  task automatic run_reset_mid();
    int bad;
    @(negedge clk);
    round = AW'(15);
    start = 1'b1;
    tick_cd = 0;
    repeat (12) begin
      @(negedge clk);
      start = 1'b0;
      drive_tick();
    end
    R = 1'b0;
    #1;
    check("rst_mid_leds", 32'(leds), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_addr", 32'(rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    R = 1'b1;
    tick = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    check("rst_mid_no_done", 32'(bad), 32'd0);
  endtask

  initial begin
    R = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tick  = 1'b0;
    round = '0;
    for (int i = 0; i < 16; i++) rom[i] = LW'(i + 1);

    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'(c % 2 == 0);
      tick  = 1'(c % 2 == 1);
      check("rst_leds", 32'(leds), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_addr", 32'(rom_addr), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    tick  = 1'b0;
    R = 1'b1;
    @(negedge clk);

    rom[0] = 4'b0100;
    run_play(0, 1'b0, 1'b0);

    rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100; rom[3] = 4'b1000;
    run_play(3, 1'b0, 1'b0);

    run_play(15, 1'b0, 1'b1);
    run_play(8, 1'b0, 1'b1);

    for (int n = 0; n < 3; n++) run_play($urandom_range(2, 15), 1'b1, 1'b1);
    for (int n = 0; n < 6; n++) run_play($urandom_range(0, 15), 1'b0, 1'b1);

    run_abort();
    run_play(5, 1'b0, 1'b1);

    run_reset_mid();
    run_play($urandom_range(0, 15), 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
